// File: rtl/lfsr_checker.sv
// Far-end checker for the serial LFSR pattern stream: deserializes valid-qualified bits
// LSB-first and compares each word against a locally predicted LFSR word.
module lfsr_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPS = 8,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Seed,
  input  logic             Serial_In,
  input  logic             Serial_Valid,
  output logic [WIDTH-1:0] P_Data,
  output logic             Done,
  output logic             Match,
  output logic [ERR_W-1:0] Err_Count,
  output logic             Overrun
);

  localparam int unsigned BitCntW  = $clog2(WIDTH + 1);
  localparam int unsigned StepCntW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {StPredict, StReady} state_t;

  state_t              state;
  logic [WIDTH-1:0]    exp_word;
  logic [WIDTH-1:0]    shreg;
  logic [BitCntW-1:0]  bit_cnt;
  logic [StepCntW-1:0] step_cnt;
  logic                complete;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[2] ^ v[1] ^ v[0], v[WIDTH-1:1]};
  endfunction

  assign complete = (state == StReady) && (bit_cnt == BitCntW'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StPredict;
      exp_word  <= Seed;
      shreg     <= '0;
      bit_cnt   <= '0;
      step_cnt  <= '0;
      P_Data    <= '0;
      Done      <= 1'b0;
      Match     <= 1'b0;
      Err_Count <= '0;
      Overrun   <= 1'b0;
    end else begin
      Done <= 1'b0;

      unique case (state)
        StPredict: begin
          exp_word <= lfsr_step(exp_word);
          if (step_cnt == StepCntW'(STEPS - 1)) begin
            step_cnt <= '0;
            state    <= StReady;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        StReady: begin
          if (complete) begin
            P_Data <= shreg;
            Match  <= (shreg == exp_word);
            Done   <= 1'b1;
            if ((shreg != exp_word) && (Err_Count != {ERR_W{1'b1}})) begin
              Err_Count <= Err_Count + 1'b1;
            end
            // Shifting a WIDTH-bit word right by WIDTH leaves nothing but zeros.
            exp_word <= '0;
            state    <= StPredict;
          end
        end
        default: state <= StPredict;
      endcase

      // Capture runs in both states; a bit landing on the completion edge starts the next word.
      if (Serial_Valid) begin
        if (complete) begin
          shreg   <= {Serial_In, shreg[WIDTH-1:1]};
          bit_cnt <= BitCntW'(1);
        end else if (bit_cnt < BitCntW'(WIDTH)) begin
          shreg   <= {Serial_In, shreg[WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (complete) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus pushes expected words, a monitor pops on Done.
module tb_lfsr_checker;

  localparam int W = 4;
  localparam int S = 8;
  localparam int E = 8;
  localparam int ErrMax = (1 << E) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] Seed = '0;
  logic         Serial_In = 1'b0;
  logic         Serial_Valid = 1'b0;
  logic [W-1:0] P_Data;
  logic         Done;
  logic         Match;
  logic [E-1:0] Err_Count;
  logic         Overrun;

  lfsr_checker #(.WIDTH(W), .STEPS(S), .ERR_W(E)) dut (
    .clk          (clk),
    .rst          (rst),
    .Seed         (Seed),
    .Serial_In    (Serial_In),
    .Serial_Valid (Serial_Valid),
    .P_Data       (P_Data),
    .Done         (Done),
    .Match        (Match),
    .Err_Count    (Err_Count),
    .Overrun      (Overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         match;
    logic [E-1:0] err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_pred;
  int   m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Predictor value after n LFSR steps, in plain integer arithmetic.
  function automatic int predict(input int start, input int n);
    int v = start;
    for (int i = 0; i < n; i++) begin
      int fb = ((v >> 2) ^ (v >> 1) ^ v) & 1;
      v = (v >> 1) | (fb << (W - 1));
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 with no word pending, expected 0 (t=%0t)",
                 $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("p_data", 32'(P_Data), 32'(e.data));
        chk("match", 32'(Match), 32'(e.match));
        chk("err_count", 32'(Err_Count), 32'(e.err));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered at a negedge; the bit is sampled on the following posedge.
  task automatic send_bit(input int b);
    Serial_Valid = 1'b1;
    Serial_In    = b[0];
    @(negedge clk);
    Serial_Valid = 1'b0;
  endtask

  task automatic send_word(input int w, input int gap_max);
    exp_t e;
    int   wv = w & ((1 << W) - 1);
    logic mt = (wv == m_pred);
    if (!mt && m_err < ErrMax) m_err++;
    e.data  = W'(wv);
    e.match = mt;
    e.err   = E'(m_err);
    sb.push_back(e);
    m_pred = predict(m_pred >> W, S);
    for (int i = 0; i < W; i++) begin
      send_bit((wv >> i) & 1);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 80) begin
      @(negedge clk);
      t++;
    end
    chk("pending_words", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Entered at a negedge; returns at the negedge where reset is released.
  task automatic do_reset(input int seed);
    Serial_Valid = 1'b0;
    Seed = W'(seed);
    rst  = 1'b1;
    #1;
    chk("rst_p_data", 32'(P_Data), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_match", 32'(Match), 32'd0);
    chk("rst_err", 32'(Err_Count), 32'd0);
    chk("rst_overrun", 32'(Overrun), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_pred = predict(seed & ((1 << W) - 1), S);
    m_err  = 0;
    sb.delete();
  endtask

  initial begin
    int lat;
    @(negedge clk);

    // Basic match, second word at predictor 0, then a mismatch.
    do_reset(4'b1001);
    idle(S);
    send_word(4'hC, 0);
    wait_done();
    send_word(4'h0, 0);
    wait_done();
    send_word(4'h1, 1);
    wait_done();

    // First-word latency with all bits delivered early.
    do_reset(4'b1001);
    send_word(4'hC, 0);
    lat = 0;
    for (int k = 5; k < 30 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (Done === 1'b1) lat = k;
    end
    chk("first_latency", 32'(lat), 32'(S + 1));
    @(negedge clk);
    wait_done();

    // Bit arriving on the completion edge becomes bit 0 of the next word.
    do_reset(4'b1001);
    send_word(4'hC, 0);
    idle(S - W);
    send_word(4'h1, 0);
    wait_done();
    chk("simul_no_overrun", 32'(Overrun), 32'd0);

    // Mid-word reset discards the partial word.
    do_reset(4'b1001);
    send_word(4'hD, 0);
    wait_done();
    send_word(4'h0, 0);
    wait_done();
    send_bit(0);
    send_bit(1);
    do_reset(4'b1001);
    send_word(4'hC, 1);
    wait_done();

    // Error counter saturation.
    do_reset(4'b1001);
    for (int i = 0; i < ErrMax + 5; i++) begin
      send_word(m_pred ^ int'($urandom_range(1, (1 << W) - 1)), 1);
      wait_done();
    end
    chk("err_saturated", 32'(Err_Count), 32'(ErrMax));

    // Randomised traffic with occasional reseeding.
    do_reset($urandom_range(0, (1 << W) - 1));
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 1) == 1) send_word(m_pred, 2);
      else send_word(int'($urandom_range(0, (1 << W) - 1)), 2);
      wait_done();
    end
    chk("no_overrun_yet", 32'(Overrun), 32'd0);

    // Overrun: fifth bit while the buffer is full during PREDICT is dropped.
    do_reset(4'b1001);
    send_word(4'hC, 0);
    send_bit(1);
    wait_done();
    chk("overrun_set", 32'(Overrun), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
